// File: rtl/seq_alu_core.sv
// Handshaked ALU keeping the 16-bit breadboard opcode map.
// Logic/add ops complete in one cycle; MUL/DIV/MOD use an iterative WIDTH-step datapath.
module seq_alu_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic [WIDTH-1:0] prev_output,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_NOP  = 4'b0000, OP_AND  = 4'b0001, OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011, OP_ADD  = 4'b0100, OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110, OP_NOT  = 4'b0111, OP_MOD  = 4'b1000;
    localparam logic [3:0] OP_NAND = 4'b1001, OP_NOR  = 4'b1010, OP_XNOR = 4'b1011;
    localparam logic [3:0] OP_SUB  = 4'b1100, OP_DIV  = 4'b1101, OP_SHL  = 4'b1110;
    localparam logic [3:0] OP_CLR  = 4'b1111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [SHW-1:0]   cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc_hi, acc_lo;

    logic             accept, iter_op, last_step;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nxt, div_quo_nxt;
    logic [WIDTH-1:0] iter_res;
    logic             iter_err;

    // Single-cycle ops; returns {error, result}.
    function automatic logic [WIDTH:0] alu_single(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] prev);
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            OP_NOP:  r = {1'b0, prev};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SHR:  r = {1'b0, a >> b[SHW-1:0]};
            OP_NOT:  r = {1'b0, ~a};
            OP_NAND: r = {1'b0, ~(a & b)};
            OP_NOR:  r = {1'b0, ~(a | b)};
            OP_XNOR: r = {1'b0, ~(a ^ b)};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_SHL:  r = {1'b0, a << b[SHW-1:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign accept    = in_valid && in_ready;
    assign iter_op   = (opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_MOD);
    assign last_step = (cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = iter_op ? BUSY : DONE;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // MUL: acc_hi:acc_lo is the partial product, multiplier shifted out of acc_lo.
    // DIV/MOD: acc_hi is the remainder, acc_lo shifts the dividend out and the quotient in.
    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
        mul_hi_nxt  = mul_sum[WIDTH:1];
        mul_lo_nxt  = {mul_sum[0], acc_lo[WIDTH-1:1]};
        div_shift   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge      = (div_shift >= {1'b0, b_q});
        div_rem_nxt = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
        div_quo_nxt = {acc_lo[WIDTH-2:0], div_ge};

        iter_res = mul_lo_nxt;
        iter_err = |mul_hi_nxt;
        if (op_q == OP_DIV) begin
            iter_res = (b_q == '0) ? '1 : div_quo_nxt;
            iter_err = (b_q == '0);
        end else if (op_q == OP_MOD) begin
            iter_res = (b_q == '0) ? a_q : div_rem_nxt;
            iter_err = (b_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            result      <= '0;
            error       <= 1'b0;
            prev_output <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q <= opcode;
                    a_q  <= a_in;
                    b_q  <= b_in;
                    cnt  <= '0;
                    acc_hi <= '0;
                    acc_lo <= (opcode == OP_MUL) ? b_in : a_in;
                    if (!iter_op) {error, result} <= alu_single(opcode, a_in, b_in, prev_output);
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (op_q == OP_MUL) begin
                        acc_hi <= mul_hi_nxt;
                        acc_lo <= mul_lo_nxt;
                    end else begin
                        acc_hi <= div_rem_nxt;
                        acc_lo <= div_quo_nxt;
                    end
                    if (last_step) begin
                        result <= iter_res;
                        error  <= iter_err;
                    end
                end
                DONE: if (out_ready) prev_output <= result;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu_core.sv
// Directed vector bench for seq_alu_core: opcode table plus backpressure and mid-op reset sequences.
module tb_seq_alu_core;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [3:0]  opcode;
    logic [15:0] a_in, b_in;
    logic        out_valid, out_ready;
    logic [15:0] result, prev_output;
    logic        error, busy;

    int tests = 0;
    int fails = 0;

    seq_alu_core #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a_in(a_in), .b_in(b_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .error(error),
        .prev_output(prev_output), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        err;
        int          lat;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Presents one op at a negedge, waits for out_valid; leaves the result unconsumed.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int busy_cycles);
        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1);
        opcode = op; a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (busy) busy_cycles++;
        end while (!out_valid && lat < 40);
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat, bc;
        vecs[0]  = '{4'b0100, 16'd355,    16'd5,     16'd360,   1'b0, 1};
        vecs[1]  = '{4'b0100, 16'd50000,  16'd50000, 16'd34464, 1'b1, 1};
        vecs[2]  = '{4'b0101, 16'd25,     16'd25,    16'd625,   1'b0, 17};
        vecs[3]  = '{4'b0101, 16'd2500,   16'd2500,  16'd24080, 1'b1, 17};
        vecs[4]  = '{4'b1101, 16'd9801,   16'd121,   16'd81,    1'b0, 17};
        vecs[5]  = '{4'b1000, 16'd209,    16'd50,    16'd9,     1'b0, 17};
        vecs[6]  = '{4'b1101, 16'd7,      16'd0,     16'hFFFF,  1'b1, 17};
        vecs[7]  = '{4'b1000, 16'd7,      16'd0,     16'd7,     1'b1, 17};
        vecs[8]  = '{4'b0011, 16'hF,      16'h9,     16'd6,     1'b0, 1};
        vecs[9]  = '{4'b0000, 16'h1234,   16'h5678,  16'd6,     1'b0, 1};
        vecs[10] = '{4'b1111, 16'h1234,   16'h5678,  16'd0,     1'b0, 1};
        vecs[11] = '{4'b1110, 16'd1,      16'd15,    16'd32768, 1'b0, 1};
        vecs[12] = '{4'b0110, 16'd32,     16'd4,     16'd2,     1'b0, 1};
        vecs[13] = '{4'b0001, 16'hF0F0,   16'hFF00,  16'hF000,  1'b0, 1};
        vecs[14] = '{4'b0010, 16'hF0F0,   16'hFF00,  16'hFFF0,  1'b0, 1};
        vecs[15] = '{4'b1001, 16'hF0F0,   16'hFF00,  16'h0FFF,  1'b0, 1};
        vecs[16] = '{4'b1010, 16'hF0F0,   16'hFF00,  16'h000F,  1'b0, 1};
        vecs[17] = '{4'b1011, 16'hF0F0,   16'hFF00,  16'hF00F,  1'b0, 1};
        vecs[18] = '{4'b0111, 16'h1234,   16'h0000,  16'hEDCB,  1'b0, 1};
        vecs[19] = '{4'b1100, 16'd5,      16'd7,     16'd65534, 1'b1, 1};
        vecs[20] = '{4'b0110, 16'h8001,   16'h0011,  16'h4000,  1'b0, 1};
        vecs[21] = '{4'b0101, 16'd65535,  16'd1,     16'd65535, 1'b0, 17};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_error", error, 0);
        chk("rst_prev_output", prev_output, 0);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_error", i), error, vecs[i].err);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].lat - 1);
            consume();
            chk($sformatf("v%0d_prev_output", i), prev_output, vecs[i].res);
            chk($sformatf("v%0d_out_valid_drop", i), out_valid, 0);
        end

        // Backpressure: SUB held in DONE for 5 cycles while a new request is offered.
        issue(4'b1100, 16'd30000, 16'd25000, lat, bc);
        for (int k = 0; k < 5; k++) begin
            opcode = 4'b0100; a_in = 16'd1; b_in = 16'd1; in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("bp%0d_result", k), result, 5000);
            chk($sformatf("bp%0d_error", k), error, 0);
            chk($sformatf("bp%0d_out_valid", k), out_valid, 1);
            chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
        end
        in_valid = 1'b0;
        consume();
        chk("bp_prev_output", prev_output, 5000);
        chk("bp_no_extra_accept", out_valid, 0);
        chk("bp_idle_in_ready", in_ready, 1);

        // Reset during the 8th BUSY cycle of a MUL.
        @(negedge clk);
        opcode = 4'b0101; a_in = 16'd300; b_in = 16'd7; in_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("mr_busy_before_reset", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_prev_output", prev_output, 0);
        issue(4'b0100, 16'd355, 16'd5, lat, bc);
        chk("mr_add_result", result, 360);
        chk("mr_add_error", error, 0);
        chk("mr_add_latency", lat, 1);
        consume();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/seq_alu_core.md
Name: seq_alu_core

Overview:
- Parametrised, handshaked successor of the 16-bit breadboard ALU, keeping the same 4-bit opcode map.
- Operands are accepted over a valid/ready input interface.
- Logic and add ops finish in one cycle; MUL, DIV and MOD run on an iterative WIDTH-cycle datapath.
- The result is held on a valid/ready output interface, and a persistent previous-result register is kept.
- Sits between the operand/opcode source (bench or sequencer) and the result consumer; replaces the free-running REG16/MUX16 arrangement.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4, power of two).
- SHW, $clog2(WIDTH), localparam; number of b bits used as shift amount.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept a new operation.
- opcode  input  4  operation select (map below).
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- out_valid  output  1  result/error valid and stable.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  operation result.
- error  output  1  overflow / divide-by-zero flag for this result.
- prev_output  output  WIDTH  last consumed result.
- busy  output  1  high in BUSY state (iterative op running).

Behaviour:
- Reset (synchronous, active-high, dominates all else): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; error=0; prev_output=0; iteration counter=0. Asserting reset mid-operation aborts it with no output.
- Opcode map:
  - 0000 NOP: result=prev_output.
  - 0001 AND; 0010 OR; 0011 XOR.
  - 0100 ADD.
  - 0101 MUL.
  - 0110 SHR: a >> b[SHW-1:0], logical.
  - 0111 NOT a.
  - 1000 MOD.
  - 1001 NAND; 1010 NOR; 1011 XNOR.
  - 1100 SUB.
  - 1101 DIV.
  - 1110 SHL: a << b[SHW-1:0].
  - 1111 CLR: result=0.
- Error rules:
  - ADD: error = carry out.
  - SUB: result = (a-b) mod 2^WIDTH; error = borrow (a<b).
  - MUL: result = low WIDTH bits of the unsigned product; error = 1 if the high WIDTH bits are nonzero.
  - DIV/MOD: unsigned restoring division. With b=0: DIV result = all ones, MOD result = a, error=1.
  - All other ops: error=0.
- States:
  - IDLE: in_ready=1. When in_valid&&in_ready is high at an edge, a_in, b_in and opcode are latched.
    - Opcode MUL/DIV/MOD: go to BUSY with counter=0.
    - Any other opcode: result/error are registered at that edge and the state goes to DONE.
  - BUSY: in_ready=0, busy=1. Performs one shift-add (MUL) or shift-subtract (DIV/MOD) step per cycle. The counter increments; after WIDTH steps result/error are registered and the state goes to DONE.
  - DONE: out_valid=1; result/error held stable; in_ready=0.
    - When out_ready is high at an edge: prev_output <= result; state goes to IDLE.
    - CLR therefore also zeroes prev_output.
- Latency:
  - Single-cycle ops: out_valid is high in the cycle after the accept edge.
  - MUL/DIV/MOD: out_valid rises WIDTH+1 edges after the accept edge (17 for WIDTH=16).
- Throughput: one operation in flight; no input bypass in DONE. in_valid while in_ready=0 is ignored; the source must hold it.
- Backpressure: DONE may persist indefinitely; outputs do not change while out_ready=0.
- NOP returns the prev_output value latched at accept time.
- out_valid and out_ready sampled high together at an edge completes exactly one transfer; out_valid drops in the next cycle.

Test Plan:
- ADD a=355, b=5 -> result=360, error=0, out_valid one cycle after accept. ADD 50000+50000 -> result=34464, error=1.
- MUL 25*25 -> 625, error=0. MUL 2500*2500 -> 24080, error=1. Both with out_valid exactly 17 cycles after accept; busy high for 16 cycles.
- DIV 9801/121 -> 81, error=0. MOD 209%50 -> 9. DIV 7/0 -> 16'hFFFF, error=1. MOD 7%0 -> 7, error=1.
- XOR 4'b1111^4'b1001 -> 6; then NOP -> 6; then CLR -> result 0 and prev_output 0. SHL 1<<15 -> 32768. SHR 32>>4 -> 2.
- Backpressure: hold out_ready=0 for 5 cycles after a SUB 30000-25000 -> result stays 5000, in_ready=0, and a new in_valid is not accepted. After out_ready=1, prev_output=5000.
- Reset asserted on the 8th BUSY cycle of a MUL -> next cycle: out_valid=0, busy=0, in_ready=1, prev_output=0. A following ADD 355+5 -> 360.
